led_bank: RTL
=============

LED_BANK -- requirements
Module: led_bank

Interface
REQ-001 SHALL expose parameter NUM_LEDS, default 24, number of LED outputs (1..64).
REQ-002 SHALL expose parameter DATA_W, default 16, bus data width (8 or 16).
REQ-003 SHALL expose parameter PWM_W, default 8, brightness counter width.
REQ-004 SHALL have one clock and a synchronous, active-high reset:
- wb_clk_i  in  1  clock, all logic on its rising edge
- wb_rst_i  in  1  synchronous active-high reset
REQ-005 SHALL have the following bus and output ports:
- wb_dat_i  in  DATA_W  write data
- wb_adr_i  in  3  word address
- CS_N  in  1  chip select, active low
- IOW_N  in  1  write strobe, active low
- IOR_N  in  1  read strobe, active low
- wb_dat_o  out  DATA_W  registered read data
- ledout  out  NUM_LEDS  registered LED drive

Function
REQ-006 SHALL accept a write on every rising edge where CS_N=0 and IOW_N=0.
REQ-007 SHALL use this register map:
- 0..3: LED data, bits [i*DATA_W +: DATA_W]
- 4: CTRL = bit0 EN, bit1 BLINK, bits[15:8] DUTY (bits[7:...] when DATA_W=8 are unused)
- 5: PERIOD, blink half-period reload
- 6: STATUS, read-only, bit0 = blink phase
- 7: reserved
REQ-008 SHALL ignore LED data bits at or above NUM_LEDS; they SHALL read 0.
REQ-009 SHALL ignore writes to addresses 6, 7 and to data words wholly above NUM_LEDS.
REQ-010 SHALL load wb_dat_o on the edge where CS_N=0 and IOR_N=0, giving 1-cycle read latency.
REQ-011 SHALL hold wb_dat_o at its previous value when no read is active.
REQ-012 SHALL return 0 on reads of reserved and unused bits.
REQ-013 On a simultaneous read and write to the same address in one cycle, SHALL return the old value and commit the new value.
REQ-014 SHALL run a free-running PWM_W-bit counter that wraps from 2^PWM_W-1 to 0.
REQ-015 SHALL define pwm_on = (cnt < DUTY), except that DUTY = all-ones forces pwm_on = 1.
REQ-016 SHALL run a DATA_W-bit blink prescaler: when it equals PERIOD it clears to 0 and toggles phase; otherwise it increments.
REQ-017 SHALL force phase = 1 while BLINK = 0 or PERIOD = 0.
REQ-018 A write to PERIOD SHALL clear the prescaler and set phase = 1 on the same edge.
REQ-019 SHALL register ledout <= data & {NUM_LEDS{EN & pwm_on & phase}}.
REQ-020 ledout SHALL reflect a register write on the second rising edge after the write is sampled.

Reset
REQ-021 While wb_rst_i = 1 at a rising edge, SHALL set:
- data registers, PERIOD, both counters, wb_dat_o, ledout = 0
- CTRL = 16'hFF01 (EN=1, BLINK=0, DUTY=FF), which keeps write-only legacy software working
- phase = 1
REQ-022 A reset asserted mid-blink or mid-PWM SHALL override any coincident bus write.
REQ-023 After reset, SHALL resume from the reset state on the next edge with wb_rst_i = 0.

Configuration
REQ-024 With macro LED_PWM_EN defined, SHALL implement the PWM counter and the DUTY field as specified.
REQ-025 With LED_PWM_EN undefined, SHALL:
- omit the PWM counter
- treat pwm_on as constant 1
- make DUTY read 0 and ignore writes to it

Verification
REQ-026 Reset, then write addr0 = 0xA5A5 and addr1 = 0x12FF -> ledout = 24'hFFA5A5; a read of addr1 returns 0x00FF.
REQ-027 Set data = 24'hFFFFFF, CTRL = 0x4001 -> ledout is all-ones for exactly 64 of every 256 cycles.
REQ-028 Set data = 24'h000001, PERIOD = 3, CTRL = 0xFF03 -> ledout[0] toggles every 4 cycles and STATUS bit0 tracks it.
REQ-029 In one cycle, write addr0 = 0x1234 and read addr0 holding 0x00AA -> wb_dat_o = 0x00AA; the next read returns 0x1234.
REQ-030 Assert wb_rst_i during an active blink with a coincident write -> all registers are at reset values and ledout = 0 on the next edge.
REQ-031 Build without LED_PWM_EN and write CTRL = 0x4001 -> ledout follows data continuously; a CTRL read returns 0x0001.

Source files
------------

// File: rtl/led_bank.sv
`default_nettype none
// ============================================================================
// Module      : led_bank
// Description : Bus-programmable LED bank. The host writes the LED on/off
//               pattern, a global enable, an optional PWM brightness duty
//               and an optional blink half-period. Each LED output is the
//               stored pattern gated by enable, PWM and blink phase, and is
//               registered before it leaves the block.
//
//               Build option:
//                 LED_PWM_EN - when defined, a free-running PWM_W-bit counter
//                              and the 8-bit DUTY field in CTRL[15:8] are
//                              built. When undefined there is no PWM counter,
//                              brightness is always full, DUTY reads 0 and
//                              writes to it are dropped.
//
// Parameters  : NUM_LEDS - number of LED outputs (1..64)
//               DATA_W   - bus data width (8 or 16)
//               PWM_W    - brightness counter width
//
// Ports       : wb_clk_i  in   1         clock, rising edge
//               wb_rst_i  in   1         synchronous active-high reset
//               wb_dat_i  in   DATA_W    write data
//               wb_adr_i  in   3         word address
//               CS_N      in   1         chip select, active low
//               IOW_N     in   1         write strobe, active low
//               IOR_N     in   1         read strobe, active low
//               wb_dat_o  out  DATA_W    registered read data
//               ledout    out  NUM_LEDS  registered LED drive
//
// Register map: 0..3 LED data word i -> LEDs [i*DATA_W +: DATA_W]
//               4    CTRL   bit0 EN, bit1 BLINK, bits[15:8] DUTY
//               5    PERIOD blink half-period reload
//               6    STATUS bit0 blink phase (read-only)
//               7    reserved, reads 0
//
// Revision    : 1.0 - initial release
// ============================================================================
module led_bank #(
   parameter int NUM_LEDS = 24,
   parameter int DATA_W   = 16,
   parameter int PWM_W    = 8
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic [DATA_W-1:0]   wb_dat_i,
   input  logic [2:0]          wb_adr_i,
   input  logic                CS_N,
   input  logic                IOW_N,
   input  logic                IOR_N,
   output logic [DATA_W-1:0]   wb_dat_o,
   output logic [NUM_LEDS-1:0] ledout
);

   // Data space covers four words, but the pattern register may be wider
   // than that (NUM_LEDS > 4*DATA_W); the padded view is the larger of both.
   localparam int c_PAD_W = (4 * DATA_W > NUM_LEDS) ? 4 * DATA_W : NUM_LEDS;

   // Reject unsupported parameter sets at elaboration time.
   generate
      if (NUM_LEDS < 1 || NUM_LEDS > 64 || (DATA_W != 8 && DATA_W != 16) ||
          PWM_W < 1 || PWM_W > 32) begin : g_bad_params
         $error("led_bank: unsupported parameter set");
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------------
   logic                w_wr;
   logic                w_rd;
   logic [3:0]          w_wr_word;
   logic                w_wr_ctrl;
   logic                w_wr_period;

   assign w_wr        = ~CS_N & ~IOW_N;
   assign w_rd        = ~CS_N & ~IOR_N;
   assign w_wr_ctrl   = w_wr & (wb_adr_i == 3'd4);
   assign w_wr_period = w_wr & (wb_adr_i == 3'd5);

   always_comb begin
      w_wr_word = 4'b0000;
      if (w_wr && !wb_adr_i[2]) begin
         w_wr_word[wb_adr_i[1:0]] = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   logic [NUM_LEDS-1:0] r_data;
   logic                r_en;
   logic                r_blink;
   logic [DATA_W-1:0]   r_period;
   logic [DATA_W-1:0]   r_presc;
   logic                r_phase;
   logic [DATA_W-1:0]   r_dat_o;
   logic [NUM_LEDS-1:0] r_ledout;

   logic [NUM_LEDS-1:0] w_data_next;
   logic                w_pwm_on;
   logic [7:0]          w_duty_rd;
   logic                w_blinking;
   logic                w_led_gate;

   // ------------------------------------------------------------------------
   // LED pattern write path. Each LED bit belongs to exactly one bus word;
   // bits that fall in a word beyond address 3 cannot be written and stay 0.
   // ------------------------------------------------------------------------
   generate
      for (genvar b = 0; b < NUM_LEDS; b++) begin : g_bit
         localparam int c_WORD = b / DATA_W;
         localparam int c_BIT  = b % DATA_W;
         if (c_WORD < 4) begin : g_wr
            assign w_data_next[b] = w_wr_word[c_WORD] ? wb_dat_i[c_BIT] : r_data[b];
         end else begin : g_ro
            assign w_data_next[b] = 1'b0;
         end
      end
   endgenerate

   // ------------------------------------------------------------------------
   // PWM brightness
   // ------------------------------------------------------------------------
`ifdef LED_PWM_EN
   // Compare at the wider of counter and duty so neither is truncated.
   localparam int  c_CMP_W    = (PWM_W > 8) ? PWM_W : 8;
   localparam bit  c_HAS_DUTY = (DATA_W >= 16);

   logic [PWM_W-1:0] r_pwm_cnt;
   logic [7:0]       r_duty;
   logic [15:0]      w_dat_ext;

   generate
      if (DATA_W >= 16) begin : g_dat_ext_wide
         assign w_dat_ext = wb_dat_i[15:0];
      end else begin : g_dat_ext_narrow
         assign w_dat_ext = {{(16 - DATA_W){1'b0}}, wb_dat_i};
      end
   endgenerate

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_pwm_cnt <= '0;
         r_duty    <= 8'hFF;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 1'b1;
         // An 8-bit bus has no room for DUTY, so it keeps its reset value.
         if (w_wr_ctrl && c_HAS_DUTY) begin
            r_duty <= w_dat_ext[15:8];
         end
      end
   end

   // All-ones duty means fully on, including the cycle where cnt = 8'hFF.
   assign w_pwm_on  = (r_duty == 8'hFF) ||
                      (c_CMP_W'(r_pwm_cnt) < c_CMP_W'(r_duty));
   assign w_duty_rd = r_duty;
`else
   assign w_pwm_on  = 1'b1;
   assign w_duty_rd = 8'h00;
`endif

   // ------------------------------------------------------------------------
   // Read mux, evaluated on pre-edge state so a same-cycle write to the
   // addressed register returns the old contents.
   // ------------------------------------------------------------------------
   logic [c_PAD_W-1:0] w_data_pad;
   logic [15:0]        w_ctrl_full;
   logic [DATA_W-1:0]  w_rd_data;

   always_comb begin
      w_data_pad                 = '0;
      w_data_pad[NUM_LEDS-1:0]   = r_data;
   end

   assign w_ctrl_full = {w_duty_rd, 6'b000000, r_blink, r_en};

   always_comb begin
      w_rd_data = '0;
      case (wb_adr_i)
         3'd0, 3'd1, 3'd2, 3'd3:
            w_rd_data = w_data_pad[int'(wb_adr_i[1:0]) * DATA_W +: DATA_W];
         3'd4:    w_rd_data = w_ctrl_full[DATA_W-1:0];
         3'd5:    w_rd_data = r_period;
         3'd6:    w_rd_data = {{(DATA_W - 1){1'b0}}, r_phase};
         default: w_rd_data = '0;
      endcase
   end

   // ------------------------------------------------------------------------
   // Blink control and register file
   // ------------------------------------------------------------------------
   // A zero period cannot produce a visible blink, so it counts as steady-on.
   assign w_blinking = r_blink && (r_period != '0);
   assign w_led_gate = r_en & w_pwm_on & r_phase;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_data   <= '0;
         r_en     <= 1'b1;
         r_blink  <= 1'b0;
         r_period <= '0;
         r_presc  <= '0;
         r_phase  <= 1'b1;
         r_dat_o  <= '0;
         r_ledout <= '0;
      end else begin
         r_data <= w_data_next;

         if (w_wr_ctrl) begin
            r_en    <= wb_dat_i[0];
            r_blink <= wb_dat_i[1];
         end

         if (w_wr_period) begin
            r_period <= wb_dat_i;
         end

         // Reloading the period restarts the blink from the lit phase.
         if (w_wr_period) begin
            r_presc <= '0;
            r_phase <= 1'b1;
         end else if (r_presc == r_period) begin
            r_presc <= '0;
            r_phase <= w_blinking ? ~r_phase : 1'b1;
         end else begin
            r_presc <= r_presc + 1'b1;
            if (!w_blinking) begin
               r_phase <= 1'b1;
            end
         end

         if (w_rd) begin
            r_dat_o <= w_rd_data;
         end

         r_ledout <= r_data & {NUM_LEDS{w_led_gate}};
      end
   end

   assign wb_dat_o = r_dat_o;
   assign ledout   = r_ledout;

endmodule
`default_nettype wire
